core_fetch: RTL and testbench

- Front-end stage directly upstream of core_decode: generates sequential halfword PCs, fetches instructions over a valid/ready instruction-memory port, and buffers them in a small prefetch FIFO.
- Presents insn/insn_pc to decode and forwards the redirect flush.
- Redirects (taken branch/jump from execute) clear the FIFO and squash any in-flight response.

---
 rtl/core_fetch_pkg.sv | 44 ++++
 rtl/core_fetch_fifo.sv | 86 ++++++++
 rtl/core_fetch.sv | 148 ++++++++++++++
 tb/tb_core_fetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_fetch_pkg.sv
//-----------------------------------------------------------------------------
// Module  : core_fetch_pkg
// Brief   : Shared micro-architecture types for the fetch stage: halfword
//           instruction/pointer types, the NOP encoding and the prefetch
//           FIFO entry layout.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

`ifndef NOP
`define NOP 16'h0000
`endif

package core_fetch_pkg;

  // One 16-bit instruction and a halfword-granular program counter
  typedef logic [15:0] hword;
  typedef logic [15:0] hptr;

  // Instruction presented to decode whenever nothing valid is available
  localparam hword NOP_INSN = `NOP;

  // One prefetch buffer slot: the instruction and the PC it was fetched from
  typedef struct packed {
    hword insn;
    hptr  pc;
  } fetch_entry;

  // Request tracking: IDLE = nothing outstanding, PEND = request held
  // waiting for mem_ready, DISC = held request whose data must be dropped
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DISC = 2'd2
  } fetch_state_e;

  // Next sequential halfword PC; wraps naturally at the type width
  function automatic hptr hptr_inc(input hptr p);
    return p + hptr'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_fetch_fifo.sv
//-----------------------------------------------------------------------------
// Module  : core_fetch_fifo
// Brief   : Prefetch FIFO of fetch_entry slots with push/pop/clear. A pushed
//           entry becomes visible at the head on the following cycle. Clear
//           dominates push and pop. DEPTH must be a power of two, >= 2.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module core_fetch_fifo
  import core_fetch_pkg::*;
#(
  parameter int   DEPTH = 4,
  localparam int  PTR_W = $clog2(DEPTH),
  localparam int  CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry       push_data,
  input  logic             pop,
  input  logic             clear,
  output fetch_entry       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  fetch_entry       r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_depth);
  assign count = r_count;

  // Pop only real data; push is allowed into a full FIFO only when a pop frees a slot
  assign w_do_pop  = pop  && !empty && !clear;
  assign w_do_push = push && !clear && (!full || w_do_pop);

  // Head is read straight from storage so it tracks rd_ptr with no extra stage
  always_comb begin
    head = r_mem[r_rd_ptr];
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: slots are only read once the count says they hold data
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_fetch.sv
//-----------------------------------------------------------------------------
// Module  : core_fetch
// Brief   : Fetch stage ahead of core_decode. Issues sequential halfword PCs
//           over a valid/ready memory port (one request outstanding), buffers
//           responses in a prefetch FIFO and presents insn/insn_pc to decode.
//           A redirect clears the FIFO, forwards flush and squashes any
//           request already presented to memory.
//           Option: define CORE_FETCH_BYPASS_EN to route a response straight
//           to decode when the FIFO is empty (saves one cycle of latency).
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module core_fetch
  import core_fetch_pkg::*;
#(
  parameter int  DEPTH    = 4,
  parameter hptr RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  branch,
  input  logic [$bits(hptr)-1:0]  branch_target,
  output logic                  mem_req,
  output logic [$bits(hptr)-1:0]  mem_addr,
  input  logic                  mem_ready,
  input  logic [$bits(hword)-1:0] mem_data,
  output logic [$bits(hword)-1:0] insn,
  output logic [$bits(hptr)-1:0]  insn_pc,
  output logic                  flush
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  fetch_state_e r_state;
  hptr          r_fetch_pc;
  hptr          r_disc_addr;

  fetch_entry       w_head;
  fetch_entry       w_push_data;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_discard;
  logic             w_hs;
  logic             w_accept;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  assign w_discard = (r_state == ST_DISC);

  // A squashed request keeps requesting regardless of occupancy; the FIFO was cleared anyway
  assign mem_req  = rst_n && (w_discard || (w_count < c_depth));
  assign mem_addr = w_discard ? r_disc_addr : r_fetch_pc;

  assign w_hs     = mem_req && mem_ready;
  // A response is usable only if it was not squashed earlier or by a redirect this cycle
  assign w_accept = w_hs && !w_discard && !branch;

`ifdef CORE_FETCH_BYPASS_EN
  assign w_bypass = w_accept && w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed response that decode takes this cycle must not also be buffered
  assign w_push      = w_accept && !w_full && !(w_bypass && !stall);
  assign w_pop       = !stall && !w_empty && !branch;
  assign w_push_data = '{insn: mem_data, pc: mem_addr};

  assign flush = branch;

  // Decode sees bypassed data first, then the FIFO head, otherwise a NOP at the fetch PC
  always_comb begin
    insn    = NOP_INSN;
    insn_pc = r_fetch_pc;
    if (w_bypass) begin
      insn    = mem_data;
      insn_pc = mem_addr;
    end else if (!w_empty) begin
      insn    = w_head.insn;
      insn_pc = w_head.pc;
    end
  end

  // Request tracking FSM and fetch PC; a redirect always wins over the sequential increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_disc_addr <= RESET_PC;
    end else begin
      if (branch) begin
        r_fetch_pc <= branch_target;
      end else if (w_hs && !w_discard) begin
        r_fetch_pc <= hptr_inc(r_fetch_pc);
      end

      unique case (r_state)
        ST_IDLE, ST_PEND: begin
          if (mem_req && !mem_ready) begin
            if (branch) begin
              // Memory may already have latched this address: finish it, then drop it
              r_state     <= ST_DISC;
              r_disc_addr <= mem_addr;
            end else begin
              r_state <= ST_PEND;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DISC: begin
          // Further redirects keep the squash; the held address never changes
          if (mem_ready) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DISC;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  core_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .clear     (branch),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_core_fetch.sv
//-----------------------------------------------------------------------------
// Module  : tb_core_fetch
// Brief   : Directed self-checking bench for core_fetch (DEPTH=4,
//           RESET_PC=0x10). Expected values are hand-derived; both the
//           default build and CORE_FETCH_BYPASS_EN are covered.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_core_fetch;
  import core_fetch_pkg::*;

`ifdef CORE_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [15:0] branch_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic [15:0] insn;
  logic [15:0] insn_pc;
  logic        flush;

  logic        use_ovr;
  logic [15:0] ovr_data;

  int n_pass;
  int n_total;
  int n_fail;
  int hs_cnt;
  int ovf_cnt;

  core_fetch #(
    .DEPTH    (4),
    .RESET_PC (16'h0010)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_data      (mem_data),
    .insn          (insn),
    .insn_pc       (insn_pc),
    .flush         (flush)
  );

  // Memory contents: a fixed scramble of the address, or an override word
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  assign mem_data = use_ovr ? ovr_data : mem_f(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Any accepted response arriving while the FIFO is full would be an overflow
  always @(negedge clk) begin
    if (rst_n && dut.w_accept && dut.w_full) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0; hs_cnt = 0; ovf_cnt = 0;
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; branch_target = 16'h0;
    mem_ready = 1'b1; use_ovr = 1'b0; ovr_data = 16'h0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req",  mem_req,  0);
    chk("rst_mem_addr", mem_addr, 32'h10);
    chk("rst_flush",    flush,    0);
    chk("rst_insn",     insn,     NOP_INSN);
    chk("rst_insn_pc",  insn_pc,  32'h10);
    next_cycle();
    rst_n = 1'b1;

    // Streaming with zero-wait memory
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("run_addr", mem_addr, 32'h10 + k);
      chk("run_pc", insn_pc, BYP ? 32'h10 + k : (k == 0 ? 32'h10 : 32'h10 + k - 1));
      chk("run_insn", insn, BYP ? mem_f(16'(16'h10 + k)) :
                            (k == 0 ? NOP_INSN : mem_f(16'(16'h10 + k - 1))));
      next_cycle();
    end

    // mem_ready low: address held, NOP to decode once drained
    mem_ready = 1'b0;
    @(negedge clk);
    chk("wait0_addr", mem_addr, 32'h16);
    next_cycle();
    @(negedge clk);
    chk("wait1_insn", insn, NOP_INSN);
    chk("wait1_pc",   insn_pc, 32'h16);
    chk("wait1_addr", mem_addr, 32'h16);
    next_cycle();
    @(negedge clk);
    chk("wait2_addr", mem_addr, 32'h16);
    chk("wait2_req",  mem_req, 1);
    next_cycle();

    // Stall 10 cycles from an empty FIFO: exactly DEPTH handshakes
    mem_ready = 1'b1;
    stall = 1'b1;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      if (mem_req && mem_ready) hs_cnt++;
      if (s == 1) begin
        chk("ready_head_pc",   insn_pc, 32'h16);
        chk("ready_head_insn", insn, mem_f(16'h16));
      end
      next_cycle();
    end
    chk("stall_handshakes", hs_cnt, 4);

    // Drain in order; request reasserts once a slot frees
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("drain_pc",   insn_pc, 32'h16 + i);
      chk("drain_insn", insn, mem_f(16'(16'h16 + i)));
      if (i == 0) chk("drain_req_off", mem_req, 0);
      if (i == 1) begin
        chk("drain_req_on", mem_req, 1);
        chk("drain_addr",   mem_addr, 32'h1A);
      end
      next_cycle();
    end
    @(negedge clk);
    chk("pre_br_addr", mem_addr, 32'h1F);
    next_cycle();

    // Redirect while a request at 0x20 is held
    mem_ready = 1'b0;
    @(negedge clk);
    chk("pend_addr", mem_addr, 32'h20);
    next_cycle();
    branch = 1'b1; branch_target = 16'h0080;
    @(negedge clk);
    chk("br_flush", flush, 1);
    chk("br_addr",  mem_addr, 32'h20);
    next_cycle();
    branch = 1'b0;
    @(negedge clk);
    chk("disc_addr",  mem_addr, 32'h20);
    chk("disc_flush", flush, 0);
    chk("disc_insn",  insn, NOP_INSN);
    chk("disc_pc",    insn_pc, 32'h80);
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("disc_hs_addr", mem_addr, 32'h20);
    chk("disc_hs_insn", insn, NOP_INSN);
    next_cycle();
    @(negedge clk);
    chk("tgt_addr", mem_addr, 32'h80);
    chk("tgt_insn", insn, BYP ? mem_f(16'h80) : NOP_INSN);
    next_cycle();
    @(negedge clk);
    chk("tgt_next_pc",   insn_pc, BYP ? 32'h81 : 32'h80);
    chk("tgt_next_insn", insn, BYP ? mem_f(16'h81) : mem_f(16'h80));
    next_cycle();

    // Fill the FIFO under stall
    stall = 1'b1;
    repeat (6) begin
      @(negedge clk);
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("full_req",  mem_req, 0);
    chk("full_head", insn_pc, BYP ? 32'h82 : 32'h81);
    next_cycle();

    // Redirect coinciding with a handshake, stalled, three entries buffered
    stall = 1'b1; branch = 1'b1; branch_target = 16'h0040;
    @(negedge clk);
    chk("brhs_req",   mem_req, 1);
    chk("brhs_addr",  mem_addr, BYP ? 32'h86 : 32'h85);
    chk("brhs_flush", flush, 1);
    next_cycle();
    stall = 1'b0; branch = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("brhs_insn", insn, NOP_INSN);
    chk("brhs_pc",   insn_pc, 32'h40);
    chk("brhs_next_addr", mem_addr, 32'h40);
    next_cycle();

    // Handshake of 0x1234 at 0x40 into an empty FIFO
    mem_ready = 1'b1; use_ovr = 1'b1; ovr_data = 16'h1234;
    @(negedge clk);
    chk("byp_insn", insn, BYP ? 32'h1234 : NOP_INSN);
    chk("byp_pc",   insn_pc, 32'h40);
    next_cycle();
    use_ovr = 1'b0;
    @(negedge clk);
    chk("byp_next_insn", insn, BYP ? mem_f(16'h41) : 32'h1234);
    chk("byp_next_pc",   insn_pc, BYP ? 32'h41 : 32'h40);

    // Asynchronous reset in mid-cycle with a request active
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",   mem_req, 0);
    chk("arst_addr",  mem_addr, 32'h10);
    chk("arst_insn",  insn, NOP_INSN);
    chk("arst_pc",    insn_pc, 32'h10);
    chk("arst_flush", flush, 0);

    chk("no_overflow", ovf_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
